// File: rtl/bbox_extract.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_extract
//  Description : Per-frame bounding-box extractor for a binarised pixel
//                stream. Tracks the min/max column and row of foreground
//                pixels over one frame and publishes the box, a validity
//                flag and the counted-pixel total at every frame boundary.
//                The results drive the overlay inputs of the VGA display.
//  Optional    : define BBOX_RUN_FILTER_EN to enable the per-row run-length
//                noise filter (runs shorter than MIN_RUN are ignored).
//  Ports       : clk, rst (sync, active high), frame_start (1-cycle pulse),
//                pix_vld / pix_fg / pix_x / pix_y (pixel stream),
//                x_min / x_max / y_min / y_max / bbox_valid / fg_count
//                (published results), frame_done (1-cycle update pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module bbox_extract #(
    parameter int H_DISP  = 640,
    parameter int V_DISP  = 480,
    parameter int MIN_PIX = 64,
    parameter int CNT_W   = 19,
    parameter int MIN_RUN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             pix_vld,
    input  logic             pix_fg,
    input  logic [11:0]      pix_x,
    input  logic [11:0]      pix_y,
    output logic [11:0]      x_min,
    output logic [11:0]      x_max,
    output logic [11:0]      y_min,
    output logic [11:0]      y_max,
    output logic             bbox_valid,
    output logic             frame_done,
    output logic [CNT_W-1:0] fg_count
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ACCUM   = 2'd1;
    localparam logic [1:0] c_ST_PUBLISH = 2'd2;

    localparam logic [11:0]      c_H_LIM   = 12'(H_DISP);
    localparam logic [11:0]      c_V_LIM   = 12'(V_DISP);
    localparam logic [CNT_W-1:0] c_MIN_PIX = CNT_W'(MIN_PIX);
    // Width of the per-pixel count increment; also sizes the run counter.
    localparam int               c_RUN_W   = $clog2(MIN_RUN + 1);

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [11:0]      r_acc_xmin, r_acc_xmax, r_acc_ymin, r_acc_ymax;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [11:0]      w_acc_xmin_d, w_acc_xmax_d, w_acc_ymin_d, w_acc_ymax_d;
    logic [CNT_W-1:0] w_acc_cnt_d;

    logic [11:0]      r_x_min, r_x_max, r_y_min, r_y_max;
    logic             r_bbox_valid, r_frame_done;
    logic [CNT_W-1:0] r_fg_count;

    logic             w_qual;        // pixel inside the active area and fg
    logic             w_count;       // pixel contributes to the accumulators
    logic [c_RUN_W-1:0] w_cnt_add;   // amount added to the pixel count
    logic [11:0]      w_xmin_cand;   // left-edge candidate for this pixel
    logic             w_active;      // accumulators follow the stream
    logic             w_publish;     // snapshot accumulators this edge

    assign w_qual = pix_vld && pix_fg && (pix_x < c_H_LIM) && (pix_y < c_V_LIM);

    // ------------------------------------------------------------------
    // Optional run-length noise filter
    // ------------------------------------------------------------------
`ifdef BBOX_RUN_FILTER_EN
    localparam logic [c_RUN_W-1:0] c_MIN_RUN = c_RUN_W'(MIN_RUN);

    logic [c_RUN_W-1:0] r_run;
    logic [11:0]        r_run_y;
    logic [c_RUN_W-1:0] w_run_base, w_run_inc, w_run_d;
    logic               w_run_first;

    always_comb begin
        // A new frame or a new row always starts a fresh run.
        w_run_base = r_run;
        if (frame_start || (pix_vld && (pix_y != r_run_y))) begin
            w_run_base = '0;
        end
        // Saturating increment: once MIN_RUN is reached it stays there.
        w_run_inc = (w_run_base == c_MIN_RUN) ? c_MIN_RUN
                                              : w_run_base + c_RUN_W'(1);
        w_run_d = w_run_base;
        if (pix_vld && !pix_fg) begin
            w_run_d = '0;
        end else if (w_qual) begin
            w_run_d = w_run_inc;
        end
        // The pixel that completes a run retroactively counts the whole
        // run and moves the left-edge candidate back to the run start.
        w_run_first = w_qual && (w_run_base == c_MIN_RUN - c_RUN_W'(1));
        w_count     = w_qual && (w_run_inc == c_MIN_RUN);
        w_cnt_add   = w_run_first ? c_MIN_RUN : c_RUN_W'(1);
        w_xmin_cand = w_run_first ? (pix_x - 12'(MIN_RUN - 1)) : pix_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run   <= '0;
            r_run_y <= '0;
        end else begin
            r_run <= w_run_d;
            if (pix_vld) begin
                r_run_y <= pix_y;
            end
        end
    end
`else
    assign w_count     = w_qual;
    assign w_cnt_add   = c_RUN_W'(1);
    assign w_xmin_cand = pix_x;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (frame_start) w_state_nxt = c_ST_ACCUM;
            c_ST_ACCUM:   if (frame_start) w_state_nxt = c_ST_PUBLISH;
            c_ST_PUBLISH: w_state_nxt = frame_start ? c_ST_PUBLISH : c_ST_ACCUM;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: control outputs. PUBLISH is the cycle in which the snapshot is
    // visible; pixels keep accumulating into the new frame meanwhile.
    // ------------------------------------------------------------------
    always_comb begin
        w_publish = 1'b0;
        w_active  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_active = frame_start;
            end
            c_ST_ACCUM, c_ST_PUBLISH: begin
                w_publish = frame_start;
                w_active  = 1'b1;
            end
            default: begin
                w_publish = 1'b0;
                w_active  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator update. On frame_start the accumulators restart from
    // their empty values, and a pixel arriving in that same cycle is
    // folded into the new frame.
    // ------------------------------------------------------------------
    logic [11:0]      w_xmin_base, w_xmax_base, w_ymin_base, w_ymax_base;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W:0]   w_cnt_sum;

    always_comb begin
        w_xmin_base = frame_start ? 12'hFFF : r_acc_xmin;
        w_xmax_base = frame_start ? 12'h000 : r_acc_xmax;
        w_ymin_base = frame_start ? 12'hFFF : r_acc_ymin;
        w_ymax_base = frame_start ? 12'h000 : r_acc_ymax;
        w_cnt_base  = frame_start ? '0      : r_acc_cnt;

        w_cnt_sum = {1'b0, w_cnt_base} + (CNT_W+1)'(w_cnt_add);

        w_acc_xmin_d = w_xmin_base;
        w_acc_xmax_d = w_xmax_base;
        w_acc_ymin_d = w_ymin_base;
        w_acc_ymax_d = w_ymax_base;
        w_acc_cnt_d  = w_cnt_base;
        if (w_count) begin
            if (w_xmin_cand < w_xmin_base) w_acc_xmin_d = w_xmin_cand;
            if (pix_x > w_xmax_base)       w_acc_xmax_d = pix_x;
            if (pix_y < w_ymin_base)       w_acc_ymin_d = pix_y;
            if (pix_y > w_ymax_base)       w_acc_ymax_d = pix_y;
            // Saturate instead of wrapping.
            w_acc_cnt_d = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_xmin <= 12'hFFF;
            r_acc_xmax <= 12'h000;
            r_acc_ymin <= 12'hFFF;
            r_acc_ymax <= 12'h000;
            r_acc_cnt  <= '0;
        end else if (w_active) begin
            r_acc_xmin <= w_acc_xmin_d;
            r_acc_xmax <= w_acc_xmax_d;
            r_acc_ymin <= w_acc_ymin_d;
            r_acc_ymax <= w_acc_ymax_d;
            r_acc_cnt  <= w_acc_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Published outputs: snapshot of the pre-reload accumulators.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_min      <= '0;
            r_x_max      <= '0;
            r_y_min      <= '0;
            r_y_max      <= '0;
            r_bbox_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_fg_count   <= '0;
        end else begin
            r_frame_done <= w_publish;
            if (w_publish) begin
                r_fg_count <= r_acc_cnt;
                if (r_acc_cnt >= c_MIN_PIX) begin
                    r_x_min      <= r_acc_xmin;
                    r_x_max      <= r_acc_xmax;
                    r_y_min      <= r_acc_ymin;
                    r_y_max      <= r_acc_ymax;
                    r_bbox_valid <= 1'b1;
                end else begin
                    r_x_min      <= '0;
                    r_x_max      <= '0;
                    r_y_min      <= '0;
                    r_y_max      <= '0;
                    r_bbox_valid <= 1'b0;
                end
            end
        end
    end

    assign x_min      = r_x_min;
    assign x_max      = r_x_max;
    assign y_min      = r_y_min;
    assign y_max      = r_y_max;
    assign bbox_valid = r_bbox_valid;
    assign frame_done = r_frame_done;
    assign fg_count   = r_fg_count;

endmodule
`default_nettype wire

// File: tb/tb_bbox_extract.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bbox_extract
//  Description : Self-checking bench for bbox_extract. A table of frames
//                (rectangle of fg pixels plus an optional extra pixel) with
//                hand-computed results, followed by directed sequences for
//                coincident frame_start, back-to-back boundaries, the run
//                filter stimulus and reset in mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bbox_extract;

    localparam int c_CNT_W = 19;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               frame_start = 1'b0;
    logic               pix_vld = 1'b0;
    logic               pix_fg = 1'b0;
    logic [11:0]        pix_x = '0;
    logic [11:0]        pix_y = '0;
    logic [11:0]        x_min, x_max, y_min, y_max;
    logic               bbox_valid, frame_done;
    logic [c_CNT_W-1:0] fg_count;

    int n_checks = 0;
    int n_errors = 0;

    bbox_extract #(
        .H_DISP  (640),
        .V_DISP  (480),
        .MIN_PIX (64),
        .CNT_W   (c_CNT_W),
        .MIN_RUN (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_vld     (pix_vld),
        .pix_fg      (pix_fg),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .x_min       (x_min),
        .x_max       (x_max),
        .y_min       (y_min),
        .y_max       (y_max),
        .bbox_valid  (bbox_valid),
        .frame_done  (frame_done),
        .fg_count    (fg_count)
    );

    always #20 clk = ~clk;

    typedef struct {
        string name;
        int    x0, x1, y0, y1;
        bit    ex_en;
        int    ex, ey;
        int    e_xmin, e_xmax, e_ymin, e_ymax;
        bit    e_valid;
        int    e_cnt;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_pub(input string name, input int e_fd, input int e_xmin,
                           input int e_xmax, input int e_ymin, input int e_ymax,
                           input int e_valid, input int e_cnt);
        chk({name, ".frame_done"}, int'(frame_done), e_fd);
        chk({name, ".x_min"},      int'(x_min),      e_xmin);
        chk({name, ".x_max"},      int'(x_max),      e_xmax);
        chk({name, ".y_min"},      int'(y_min),      e_ymin);
        chk({name, ".y_max"},      int'(y_max),      e_ymax);
        chk({name, ".bbox_valid"}, int'(bbox_valid), e_valid);
        chk({name, ".fg_count"},   int'(fg_count),   e_cnt);
    endtask

    task automatic drive_px(input int x, input int y, input bit fg);
        pix_vld = 1'b1;
        pix_fg  = fg;
        pix_x   = 12'(x);
        pix_y   = 12'(y);
        tick();
        pix_vld = 1'b0;
        pix_fg  = 1'b0;
    endtask

    task automatic drive_rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                drive_px(x, y, 1'b1);
            end
        end
    endtask

    // frame_start pulse, optionally carrying a fg pixel in the same cycle.
    task automatic pulse_fs(input bit with_px, input int x, input int y);
        frame_start = 1'b1;
        if (with_px) begin
            pix_vld = 1'b1;
            pix_fg  = 1'b1;
            pix_x   = 12'(x);
            pix_y   = 12'(y);
        end
        tick();
        frame_start = 1'b0;
        pix_vld     = 1'b0;
        pix_fg      = 1'b0;
    endtask

    initial begin
        //            name       x0   x1   y0   y1  ex ex   ey   xmin xmax ymin ymax v  cnt
        tbl[0] = '{"block",     100, 199,  50, 149, 0,  0,  0,  100, 199,  50, 149, 1, 10000};
        tbl[1] = '{"ten_px",     10,  19,   7,   7, 0,  0,  0,    0,   0,   0,   0, 0, 10};
        tbl[2] = '{"min_pix",     0,   7,   0,   7, 0,  0,  0,    0,   7,   0,   7, 1, 64};
        tbl[3] = '{"below_min",   0,   8,   0,   6, 0,  0,  0,    0,   0,   0,   0, 0, 63};
        tbl[4] = '{"x_edge",    635, 644,   0,  19, 0,  0,  0,  635, 639,   0,  19, 1, 100};
        tbl[5] = '{"y_edge",      0,  19, 475, 484, 0,  0,  0,    0,  19, 475, 479, 1, 100};
        tbl[6] = '{"corner_x700",600, 639, 478, 479, 1, 700, 10, 600, 639, 478, 479, 1, 80};

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk_pub("reset", 0, 0, 0, 0, 0, 0, 0);

        // First boundary out of IDLE starts a frame but publishes nothing.
        pulse_fs(1'b0, 0, 0);
        chk("idle_fs.frame_done", int'(frame_done), 0);

        // Table-driven frames: each pulse closes one frame and opens the next.
        for (int i = 0; i < 7; i++) begin
            drive_rect(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1);
            if (tbl[i].ex_en) drive_px(tbl[i].ex, tbl[i].ey, 1'b1);
            pulse_fs(1'b0, 0, 0);
            chk_pub(tbl[i].name, 1, tbl[i].e_xmin, tbl[i].e_xmax, tbl[i].e_ymin,
                    tbl[i].e_ymax, int'(tbl[i].e_valid), tbl[i].e_cnt);
            tick();
            chk({tbl[i].name, ".hold_fd"},    int'(frame_done), 0);
            chk({tbl[i].name, ".hold_count"}, int'(fg_count),   tbl[i].e_cnt);
        end

        // frame_start coincident with a fg pixel: the pixel opens the new frame.
        drive_rect(20, 29, 20, 29);
        pulse_fs(1'b1, 5, 5);
        chk_pub("coinc_old", 1, 20, 29, 20, 29, 1, 100);
        drive_rect(20, 29, 20, 29);
        pulse_fs(1'b0, 0, 0);
`ifdef BBOX_RUN_FILTER_EN
        chk_pub("coinc_new", 1, 20, 29, 20, 29, 1, 100);
`else
        chk_pub("coinc_new", 1, 5, 29, 5, 29, 1, 101);
`endif

        // Back-to-back boundaries: an empty frame, then a one-pixel frame.
        pulse_fs(1'b1, 3, 4);
        chk_pub("b2b_empty", 1, 0, 0, 0, 0, 0, 0);
        pulse_fs(1'b0, 0, 0);
`ifdef BBOX_RUN_FILTER_EN
        chk_pub("b2b_one_px", 1, 0, 0, 0, 0, 0, 0);
`else
        chk_pub("b2b_one_px", 1, 0, 0, 0, 0, 0, 1);
`endif

        // Row with a 3-pixel speck and a 6-pixel run separated by
        // background, plus a 70-pixel block to make the box valid.
        for (int x = 10; x <= 25; x++) begin
            drive_px(x, 30, (x <= 12) || (x >= 20));
        end
        drive_rect(30, 39, 31, 37);
        pulse_fs(1'b0, 0, 0);
`ifdef BBOX_RUN_FILTER_EN
        chk_pub("run_filter", 1, 20, 39, 30, 37, 1, 76);
`else
        chk_pub("run_filter", 1, 10, 39, 30, 37, 1, 79);
`endif

        // Reset in mid-frame discards the partial frame.
        drive_rect(0, 49, 0, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_pub("mid_rst", 0, 0, 0, 0, 0, 0, 0);
        pulse_fs(1'b0, 0, 0);
        chk("mid_rst.first_fs_fd", int'(frame_done), 0);
        chk("mid_rst.first_fs_cnt", int'(fg_count), 0);
        drive_rect(0, 7, 0, 7);
        pulse_fs(1'b0, 0, 0);
        chk_pub("after_rst", 1, 0, 7, 0, 7, 1, 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
